load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Single-port data RAM load/store unit: byte/half/word access, sub-word stores via read-modify-write.
// Loads and word stores respond 2 cycles after acceptance, sub-word stores 3, rejected requests 1.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_write,
  output logic        ram_write_en,
  output logic        ram_read_en,
  input  logic [31:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    req_err = (mem_read && mem_write) || (size == 2'b11) ||
              (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) ||
              ({2'b00, addr[31:2]} >= MEM_WORDS_W);
    accept  = req_valid && req_ready && (mem_read || mem_write);
  end

  always_comb begin
    byte_sel = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   load_ext = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   load_ext = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: load_ext = rdata_q;
    endcase

    // Only the addressed lane(s) of the captured word are replaced.
    merged = rdata_q;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    size_d    = size_q;
    sext_d    = sext_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_load_d = mem_read;
          size_d    = size;
          sext_d    = sign_ext;
          addr_d    = addr;
          wdata_d   = store_data;
          rdata_d   = 32'h0;
          err_d     = req_err;
          if (req_err)              state_d = S_RESP;
          else if (mem_read)        state_d = S_RD;
          else if (size == 2'b10)   state_d = S_WR;
          else                      state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        rdata_d = ram_data_out;
        state_d = S_RESP;
      end
      S_WR:     state_d = S_RESP;
      S_RMW_RD: begin
        rdata_d = ram_data_out;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Outputs are gated by reset so an in-flight operation is silenced in the reset cycle itself.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    err            = 1'b0;
    load_data      = 32'h0;
    ram_address    = 32'h0;
    ram_data_write = 32'h0;
    ram_write_en   = 1'b0;
    ram_read_en    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: req_ready = 1'b1;
        S_RD, S_RMW_RD: begin
          ram_read_en = 1'b1;
          ram_address = {addr_q[31:2], 2'b00};
        end
        S_WR: begin
          ram_write_en   = 1'b1;
          ram_address    = {addr_q[31:2], 2'b00};
          ram_data_write = wdata_q;
        end
        S_RMW_WR: begin
          ram_write_en   = 1'b1;
          ram_address    = {addr_q[31:2], 2'b00};
          ram_data_write = merged;
        end
        S_RESP: begin
          resp_valid = 1'b1;
          err        = err_q;
          if (is_load_q && !err_q) load_data = load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule
